// File: rtl/fir_seq_pkg.sv
// Shared state encoding and default sizing for the FIR sample sequencer.
package fir_seq_pkg;

    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_LAST_ADDR = 501;
    localparam int DEF_DATA_W    = 35;
    localparam int DEF_FIR_LAT   = 4;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic logic is_active(input seq_state_t s);
        return (s == ST_RUN) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/fir_seq_valid_pipe.sv
// Token shift register that mirrors the FIR pipeline: a 1 marks a stage carrying a real sample.
module fir_seq_valid_pipe
    import fir_seq_pkg::*;
#(
    parameter int DEPTH = DEF_FIR_LAT
)(
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_din,
    output logic o_last,
    output logic o_all_zero,
    output logic o_upper_zero
);

    logic [DEPTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_pipe <= '0;
                end else if (i_en) begin
                    r_pipe <= i_din;
                end
            end
            assign o_upper_zero = 1'b1;
        end else begin : g_multi
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_pipe <= '0;
                end else if (i_en) begin
                    r_pipe <= {r_pipe[DEPTH-2:0], i_din};
                end
            end
            // Every stage except the output one; lets the owner see the pipe draining this cycle.
            assign o_upper_zero = ~|r_pipe[DEPTH-2:0];
        end
    endgenerate

    assign o_last     = r_pipe[DEPTH-1];
    assign o_all_zero = ~|r_pipe;

endmodule

// File: rtl/fir_sample_sequencer.sv
// Drives sample-ROM addresses and the FIR enable, and hands FIR results out over valid/ready.
// Optional peak-magnitude tracker is built only when FIR_SEQ_PEAK_EN is defined.
module fir_sample_sequencer
    import fir_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LAST_ADDR = DEF_LAST_ADDR,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FIR_LAT   = DEF_FIR_LAT,
    parameter int CNT_W     = DEF_CNT_W
)(
    input  logic              i_clk,
    input  logic              i_rest,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_mode,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_fir_en,
    input  logic [DATA_W-1:0] i_fir_out,
    output logic [DATA_W-1:0] o_res_data,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_res_cnt,
    output logic [DATA_W-1:0] o_peak_abs
);

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_res_cnt;

    logic w_res_valid;
    logic w_stall;
    logic w_fir_en;
    logic w_xfer;
    logic w_start_accept;
    logic w_pipe_load;
    logic w_pipe_clr;
    logic w_pipe_all_zero;
    logic w_pipe_upper_zero;

    // r_busy tracks RUN|FLUSH as a register, so the enable needs no state decode.
    assign w_stall        = w_res_valid & ~i_res_ready;
    assign w_fir_en       = r_busy & ~w_stall;
    assign w_xfer         = w_res_valid & i_res_ready;
    assign w_start_accept = (r_state == ST_IDLE) && i_start;
    assign w_pipe_load    = (r_state == ST_RUN);
    assign w_pipe_clr     = i_rest | w_start_accept;

    fir_seq_valid_pipe #(
        .DEPTH(FIR_LAT)
    ) u_valid_pipe (
        .i_clk        (i_clk),
        .i_clr        (w_pipe_clr),
        .i_en         (w_fir_en),
        .i_din        (w_pipe_load),
        .o_last       (w_res_valid),
        .o_all_zero   (w_pipe_all_zero),
        .o_upper_zero (w_pipe_upper_zero)
    );

    // FLUSH may end in the same cycle the final token is accepted, so DONE follows it directly.
    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_rom_addr <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        r_state <= ST_FLUSH;
                    end else if (w_fir_en) begin
                        if (r_rom_addr == LAST_A) begin
                            if (i_loop_mode) begin
                                r_rom_addr <= '0;
                            end else begin
                                r_state <= ST_FLUSH;
                            end
                        end else begin
                            r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_pipe_all_zero || (w_pipe_upper_zero && !w_stall)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_res_cnt <= '0;
        end else if (w_start_accept) begin
            r_res_cnt <= '0;
        end else if (w_xfer && (r_res_cnt != CNT_MAX)) begin
            r_res_cnt <= r_res_cnt + CNT_W'(1);
        end
    end

`ifdef FIR_SEQ_PEAK_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] r_peak_abs;

    // The most negative value has no positive twin, so it clips to the largest positive one.
    always_comb begin
        w_abs = i_fir_out;
        if (i_fir_out == MOST_NEG) begin
            w_abs = MAX_POS;
        end else if (i_fir_out[DATA_W-1]) begin
            w_abs = (~i_fir_out) + DATA_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_peak_abs <= '0;
        end else if (w_start_accept) begin
            r_peak_abs <= '0;
        end else if (w_xfer && (w_abs > r_peak_abs)) begin
            r_peak_abs <= w_abs;
        end
    end

    assign o_peak_abs = r_peak_abs;
`else
    assign o_peak_abs = '0;
`endif

    assign o_rom_addr  = r_rom_addr;
    assign o_fir_en    = w_fir_en;
    assign o_res_data  = i_fir_out;
    assign o_res_valid = w_res_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_res_cnt   = r_res_cnt;

endmodule
